voq_scheduler: RTL and testbench

Per-ingress-port scheduler that decides which of the four virtual output queues (VOQs) the port drains in each switch time slot. It keeps an occupancy count per VOQ and a round-robin priority pointer. On each slot start it selects the first non-empty VOQ whose egress is ready, then runs a valid/ready dequeue handshake with the VOQ buffer memory. It sits between the VOQ buffer (enqueue/dequeue side) and the crossbar slot timer.

---
 rtl/voq_scheduler_pkg.sv | 14 +
 rtl/voq_scheduler_rr_select.sv | 21 ++
 rtl/voq_scheduler.sv | 132 +++++++++++++
 tb/tb_voq_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voq_scheduler_pkg.sv
// Switch-wide scheduler definitions: VOQ count, VOQ index type and scheduler state encoding.
package voq_scheduler_pkg;
  localparam int NUM_VOQ = 4;
  localparam int VOQ_W   = 2;

  typedef logic [VOQ_W-1:0] voq_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_ISSUE,
    ST_WAIT
  } sched_state_t;
endpackage

// File: rtl/voq_scheduler_rr_select.sv
// Combinational round-robin finder: first set bit of req scanning upward from start, wrapping.
module rr_select
  import voq_scheduler_pkg::*;
(
  input  logic [NUM_VOQ-1:0] req,
  input  voq_idx_t           start,
  output logic               none_set,
  output voq_idx_t           idx
);
  logic [NUM_VOQ-1:0] rot;

  always_comb begin
    // rot[k] holds request (start + k) mod NUM_VOQ
    rot      = NUM_VOQ'({req, req} >> start);
    none_set = (req == '0);
    idx      = start;
    for (int k = NUM_VOQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = start + voq_idx_t'(k);
    end
  end
endmodule

// File: rtl/voq_scheduler.sv
// Per-ingress VOQ scheduler: occupancy counters, round-robin pick and dequeue handshake FSM.
// Optional VOQ_SCHED_STATS_EN adds saturating per-VOQ grant counters on port grant_cnt.
module voq_scheduler #(
  parameter int NUM_VOQ = voq_scheduler_pkg::NUM_VOQ,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sched_start,
  input  logic               enq_valid,
  input  logic [1:0]         enq_voq,
  input  logic [NUM_VOQ-1:0] egress_ready,
  input  logic               deq_ready,
  input  logic               deq_done,
  output logic               deq_valid,
  output logic [1:0]         deq_voq,
  output logic [NUM_VOQ-1:0] voq_empty,
  output logic               busy,
  output logic               overflow
`ifdef VOQ_SCHED_STATS_EN
  ,
  output logic [NUM_VOQ-1:0][15:0] grant_cnt
`endif
);
  import voq_scheduler_pkg::*;

  sched_state_t       state_reg;
  voq_idx_t           rr_ptr_reg;
  logic [NUM_VOQ-1:0] eligible;
  logic [NUM_VOQ-1:0] full_hit;
  logic               accept;
  logic               none_set;
  voq_idx_t           pick_idx;

  assign accept   = deq_valid & deq_ready;
  assign eligible = ~voq_empty & egress_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOQ; gi++) begin : g_voq
      logic [CNT_W-1:0] count_reg;
      logic             enq_hit;
      logic             acc_hit;

      assign enq_hit = enq_valid && (enq_voq == voq_idx_t'(gi));
      assign acc_hit = accept && (deq_voq == voq_idx_t'(gi));

      // Simultaneous enqueue and accept cancel; a full counter drops the enqueue.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= '0;
        end else if (enq_hit && !acc_hit) begin
          if (count_reg != '1) count_reg <= count_reg + 1'b1;
        end else if (acc_hit && !enq_hit) begin
          count_reg <= count_reg - 1'b1;
        end
      end

      assign voq_empty[gi] = (count_reg == '0);
      assign full_hit[gi]  = enq_hit && !acc_hit && (count_reg == '1);

`ifdef VOQ_SCHED_STATS_EN
      logic [15:0] grant_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          grant_reg <= '0;
        end else if (acc_hit && grant_reg != 16'hFFFF) begin
          grant_reg <= grant_reg + 16'd1;
        end
      end
      assign grant_cnt[gi] = grant_reg;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (|full_hit) begin
      overflow <= 1'b1;
    end
  end

  rr_select u_rr_select (
    .req      (eligible),
    .start    (rr_ptr_reg),
    .none_set (none_set),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      deq_valid  <= 1'b0;
      deq_voq    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sched_start) begin
            state_reg <= ST_PICK;
            busy      <= 1'b1;
          end
        end
        ST_PICK: begin
          if (none_set) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg <= ST_ISSUE;
            deq_voq   <= pick_idx;
            deq_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (deq_ready) begin
            state_reg  <= ST_WAIT;
            deq_valid  <= 1'b0;
            rr_ptr_reg <= deq_voq + 2'd1;
          end
        end
        ST_WAIT: begin
          if (deq_done) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_voq_scheduler.sv
// Scoreboard bench for voq_scheduler: driver predicts picks from a slot-level model, monitor compares.
module tb_voq_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sched_start = 1'b0;
  logic       enq_valid = 1'b0;
  logic [1:0] enq_voq = 2'd0;
  logic [3:0] egress_ready = 4'd0;
  logic       deq_ready = 1'b0;
  logic       deq_done = 1'b0;
  logic       deq_valid;
  logic [1:0] deq_voq;
  logic [3:0] voq_empty;
  logic       busy;
  logic       overflow;
`ifdef VOQ_SCHED_STATS_EN
  logic [3:0][15:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  voq_scheduler #(.NUM_VOQ(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .sched_start  (sched_start),
    .enq_valid    (enq_valid),
    .enq_voq      (enq_voq),
    .egress_ready (egress_ready),
    .deq_ready    (deq_ready),
    .deq_done     (deq_done),
    .deq_valid    (deq_valid),
    .deq_voq      (deq_voq),
    .voq_empty    (voq_empty),
    .busy         (busy),
    .overflow     (overflow)
`ifdef VOQ_SCHED_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  // Reference model: packet counts per VOQ, priority pointer, sticky overflow
  int m_cnt[4];
  int m_grant[4];
  int m_rr;
  bit m_ovf;
  bit exp_busy, exp_valid, chk_rst;
  bit mon_en = 1'b0;
  int exp_q[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit rb(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]   = 0;
      m_grant[i] = 0;
    end
    m_rr  = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_apply(input bit ev, input int eq, input int acc);
    if (!(ev && acc == eq)) begin
      if (ev) begin
        if (m_cnt[eq] == 255) m_ovf = 1'b1;
        else m_cnt[eq]++;
      end
      if (acc >= 0) m_cnt[acc]--;
    end
    if (acc >= 0) begin
      m_rr = (acc + 1) % 4;
      if (m_grant[acc] < 65535) m_grant[acc]++;
    end
  endtask

  // Highest-priority non-empty VOQ with ready egress, starting from the pointer
  function automatic int model_pick(input logic [3:0] egr);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_rr + k) % 4;
      if (m_cnt[idx] > 0 && egr[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: drive inputs, let the edge happen, update model, set expected state for this cycle
  task automatic cyc(input bit ss, input bit ev, input int eq, input bit dr, input bit dd,
                     input bit rst, input int acc, input bit nb, input bit nv);
    sched_start = ss;
    enq_valid   = ev;
    enq_voq     = eq[1:0];
    deq_ready   = dr;
    deq_done    = dd;
    reset       = rst;
    @(posedge clk);
    if (rst) model_reset();
    else model_apply(ev, eq, acc);
    exp_busy  = nb;
    exp_valid = nv;
    chk_rst   = rst;
    #1;
  endtask

  task automatic rand_enq(input bit noise, output bit ev, output int eq);
    ev = noise ? rb(20) : 1'b0;
    eq = int'($urandom_range(3));
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 1, -1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic enq(input int q, input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, q, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic run_slot(input logic [3:0] egr, input int pre_idle, input int issue_wait,
                          input int wait_len, input int acc_enq, input bit noise);
    int pick;
    bit ev;
    int eq;
    for (int i = 0; i < pre_idle; i++) begin
      rand_enq(noise, ev, eq);
      cyc(0, ev, eq, 0, noise && rb(30), 0, -1, 0, 0);
    end
    rand_enq(noise, ev, eq);
    cyc(1, ev, eq, 0, 0, 0, -1, 1, 0);
    egress_ready = egr;
    pick = model_pick(egr);
    rand_enq(noise, ev, eq);
    cyc(0, ev, eq, 0, 0, 0, -1, pick >= 0, pick >= 0);
    if (pick < 0) return;
    exp_q.push_back(pick);
    for (int i = 0; i < issue_wait; i++) begin
      if (noise) egress_ready = 4'($urandom);
      rand_enq(noise, ev, eq);
      cyc(noise && rb(30), ev, eq, 0, noise && rb(30), 0, -1, 1, 1);
    end
    if (acc_enq >= 0) begin
      ev = 1'b1;
      eq = acc_enq;
    end else begin
      rand_enq(noise, ev, eq);
    end
    cyc(noise && rb(30), ev, eq, 1, 0, 0, pick, 1, 0);
    for (int i = 0; i < wait_len; i++) begin
      rand_enq(noise, ev, eq);
      cyc(noise && rb(30), ev, eq, 0, 0, 0, -1, 1, 0);
    end
    rand_enq(noise, ev, eq);
    cyc(0, ev, eq, 0, 1, 0, -1, 0, 0);
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each dequeue handshake
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] empty_exp;
      for (int i = 0; i < 4; i++) empty_exp[i] = (m_cnt[i] == 0);
      check("busy", int'(busy), int'(exp_busy));
      check("deq_valid", int'(deq_valid), int'(exp_valid));
      check("voq_empty", int'(voq_empty), int'(empty_exp));
      check("overflow", int'(overflow), int'(m_ovf));
      if (chk_rst) check("deq_voq_reset", int'(deq_voq), 0);
`ifdef VOQ_SCHED_STATS_EN
      for (int i = 0; i < 4; i++) check("grant_cnt", int'(grant_cnt[i]), m_grant[i]);
`endif
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL deq_grant: got voq %0d expected no request (t=%0t)", deq_voq, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("deq_voq", int'(deq_voq), e);
          $display("grant voq=%0d expected=%0d", deq_voq, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    cyc(0, 0, 0, 0, 0, 1, -1, 0, 0);
    mon_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 1, -1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, -1, 0, 0);

    // single packet to VOQ 2; pointer then moves to 3
    enq(2, 1);
    run_slot(4'b1111, 0, 0, 1, -1, 0);
    enq(3, 1);
    enq(0, 1);
    run_slot(4'b1111, 0, 1, 0, -1, 0);

    // two packets per VOQ, rotating picks
    do_reset();
    for (int q = 0; q < 4; q++) enq(q, 2);
    for (int s = 0; s < 5; s++) run_slot(4'b1111, 0, s % 2, 1, -1, 0);

    // VOQ 3 masked by egress, wrap to VOQ 1
    do_reset();
    enq(1, 2);
    enq(3, 1);
    run_slot(4'b1111, 0, 0, 0, -1, 0);
    run_slot(4'b0111, 0, 0, 0, -1, 0);

    // nothing eligible: immediate return to idle
    do_reset();
    run_slot(4'b1111, 0, 0, 0, -1, 0);
    enq(2, 1);
    run_slot(4'b1011, 1, 0, 0, -1, 0);

    // enqueue and accept on VOQ 0 together, then drain exactly three
    do_reset();
    enq(0, 3);
    run_slot(4'b0001, 0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) run_slot(4'b0001, 0, 0, 0, -1, 0);

    // saturating count and sticky overflow
    do_reset();
    enq(1, 256);
    enq(1, 1);
    run_slot(4'b0010, 0, 0, 0, -1, 0);

    // reset while waiting for deq_done; stray deq_done afterwards is ignored
    do_reset();
    enq(0, 2);
    cyc(1, 0, 0, 0, 0, 0, -1, 1, 0);
    egress_ready = 4'b1111;
    exp_q.push_back(model_pick(4'b1111));
    cyc(0, 0, 0, 0, 0, 0, -1, 1, 1);
    cyc(1, 0, 0, 0, 1, 0, -1, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, -1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, -1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, -1, 0, 0);

    // randomized traffic with ignored control noise
    do_reset();
    for (int q = 0; q < 4; q++) enq(q, int'($urandom_range(3)));
    for (int s = 0; s < 150; s++) begin
      run_slot(4'($urandom), int'($urandom_range(2)), int'($urandom_range(3)),
               int'($urandom_range(3)), -1, 1'b1);
    end
    cyc(0, 0, 0, 0, 0, 0, -1, 0, 0);
    mon_en = 1'b0;
    check("pending_grants", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
